// File: rtl/tick_prescaler.sv
// Programmable-rate one-cycle enable generator with continuous, one-shot and burst modes.
// Optional user-programmable top limit when TICK_PRESCALER_USER_LIMIT_EN is defined.
module tick_prescaler #(
  parameter int unsigned NB_COUNT   = 32,
  parameter int unsigned NB_SEL     = 2,
  parameter int unsigned SHIFT_BASE = 10,
  parameter int unsigned NB_BURST   = 8
) (
  input  logic                clk,
  input  logic                i_ck_reset,
  input  logic                i_count_enable,
  input  logic [NB_SEL-1:0]   i_count_sel,
  input  logic [1:0]          i_mode,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic [NB_BURST-1:0] i_burst_len,
`ifdef TICK_PRESCALER_USER_LIMIT_EN
  input  logic                i_limit_wr,
  input  logic [NB_COUNT-1:0] i_limit_data,
`endif
  output logic                o_shift_enable,
  output logic                o_done,
  output logic                o_busy,
  output logic [NB_COUNT-1:0] o_count
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    M_CONT    = 2'b00,
    M_ONESHOT = 2'b01,
    M_BURST   = 2'b10
  } mode_e;

  localparam logic [NB_COUNT-1:0] ALL_ONES = '1;
  localparam int unsigned         NUM_SEL  = 2**NB_SEL;

  state_e                state_q, state_d;
  mode_e                 mode_q, mode_d;
  logic [NB_COUNT-1:0]   count_q, count_d;
  logic [NB_BURST-1:0]   remaining_q, remaining_d;
  logic                  tick_q, tick_d;
  logic                  done_q, done_d;
  logic [NB_COUNT-1:0]   preset_lim [NUM_SEL];
  logic [NB_COUNT-1:0]   limit;
  mode_e                 mode_in;

`ifdef TICK_PRESCALER_USER_LIMIT_EN
  logic [NB_COUNT-1:0]   user_limit_q;

  always_ff @(posedge clk or posedge i_ck_reset) begin
    if (i_ck_reset) begin
      user_limit_q <= ALL_ONES >> SHIFT_BASE;
    end else if (i_limit_wr) begin
      user_limit_q <= i_limit_data;
    end
  end
`endif

  // Preset k is 2^(NB_COUNT-SHIFT_BASE+k)-1, i.e. all-ones shifted right by SHIFT_BASE-k.
  always_comb begin
    for (int unsigned k = 0; k < NUM_SEL; k++) begin
      preset_lim[k] = ALL_ONES >> (SHIFT_BASE - k);
    end
  end

  always_comb begin
    limit = preset_lim[i_count_sel];
`ifdef TICK_PRESCALER_USER_LIMIT_EN
    if (&i_count_sel) begin
      limit = user_limit_q;
    end
`endif
  end

  always_comb begin
    unique case (i_mode)
      2'b01:   mode_in = M_ONESHOT;
      2'b10:   mode_in = M_BURST;
      default: mode_in = M_CONT;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    count_d     = count_q;
    remaining_d = remaining_q;
    tick_d      = 1'b0;
    done_d      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        count_d = '0;
        if (i_start && !i_stop && i_count_enable) begin
          state_d = S_RUN;
          mode_d  = mode_in;
          if (mode_in == M_ONESHOT) begin
            remaining_d = NB_BURST'(1);
          end else if (mode_in == M_BURST) begin
            remaining_d = (i_burst_len == '0) ? NB_BURST'(1) : i_burst_len;
          end
        end
      end
      S_RUN: begin
        // Stop wins over a coinciding terminal count: no tick, no done.
        if (i_stop) begin
          state_d = S_IDLE;
          count_d = '0;
        end else if (i_count_enable) begin
          if (count_q >= limit) begin
            count_d = '0;
            tick_d  = 1'b1;
            if (mode_q != M_CONT) begin
              remaining_d = remaining_q - 1'b1;
              if (remaining_q == NB_BURST'(1)) begin
                done_d  = 1'b1;
                state_d = S_IDLE;
              end
            end
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge i_ck_reset) begin
    if (i_ck_reset) begin
      state_q     <= S_IDLE;
      mode_q      <= M_CONT;
      count_q     <= '0;
      remaining_q <= '0;
      tick_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      count_q     <= count_d;
      remaining_q <= remaining_d;
      tick_q      <= tick_d;
      done_q      <= done_d;
    end
  end

  assign o_shift_enable = tick_q;
  assign o_done         = done_q;
  assign o_busy         = (state_q == S_RUN);
  assign o_count        = count_q;

endmodule

// File: tb/tb_tick_prescaler.sv
// Scoreboard bench for tick_prescaler: an arithmetic reference model queues expected
// outputs per stimulus cycle; a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_tick_prescaler;

  localparam int unsigned NB_COUNT   = 8;
  localparam int unsigned NB_SEL     = 2;
  localparam int unsigned SHIFT_BASE = 6;
  localparam int unsigned NB_BURST   = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, start = 1'b0, stop = 1'b0;
  logic [1:0] sel = '0, mode = '0;
  logic [3:0] blen = '0;
  logic       lim_wr = 1'b0;
  logic [7:0] lim_data = '0;
  logic       tick, done, busy;
  logic [7:0] cnt;

  always #5 clk = ~clk;

  tick_prescaler #(
    .NB_COUNT  (NB_COUNT),
    .NB_SEL    (NB_SEL),
    .SHIFT_BASE(SHIFT_BASE),
    .NB_BURST  (NB_BURST)
  ) dut (
    .clk           (clk),
    .i_ck_reset    (rst),
    .i_count_enable(en),
    .i_count_sel   (sel),
    .i_mode        (mode),
    .i_start       (start),
    .i_stop        (stop),
    .i_burst_len   (blen),
`ifdef TICK_PRESCALER_USER_LIMIT_EN
    .i_limit_wr    (lim_wr),
    .i_limit_data  (lim_data),
`endif
    .o_shift_enable(tick),
    .o_done        (done),
    .o_busy        (busy),
    .o_count       (cnt)
  );

  typedef struct packed {
    logic       tick;
    logic       done;
    logic       busy;
    logic [7:0] count;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0, passed = 0;
  int   tick_seen = 0, done_seen = 0;

  // Reference model: period index, ticks still owed, run flag.
  bit m_busy;
  int m_count, m_left, m_mode, m_user;

  function automatic void chk(string name, int act, int expv);
    checks++;
    if (act == expv) passed++;
    else $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, expv);
  endfunction

  function automatic int model_limit(int s);
`ifdef TICK_PRESCALER_USER_LIMIT_EN
    if (s == 3) return m_user;
`endif
    return (1 << (int'(NB_COUNT) - int'(SHIFT_BASE) + s)) - 1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_count = 0; m_left = 0; m_mode = 0;
    m_user = (1 << (int'(NB_COUNT) - int'(SHIFT_BASE))) - 1;
    exp_q.delete();
  endtask

  task automatic model_step();
    exp_t x;
    x = '0;
    if (!m_busy) begin
      m_count = 0;
      if (start && !stop && en) begin
        m_busy = 1;
        m_mode = (mode == 2'd1) ? 1 : (mode == 2'd2) ? 2 : 0;
        m_left = (m_mode == 1) ? 1 : ((blen == 0) ? 1 : int'(blen));
      end
    end else if (stop) begin
      m_busy = 0;
      m_count = 0;
    end else if (en) begin
      if (m_count >= model_limit(int'(sel))) begin
        m_count = 0;
        x.tick = 1'b1;
        if (m_mode != 0) begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            x.done = 1'b1;
            m_busy = 0;
          end
        end
      end else begin
        m_count = m_count + 1;
      end
    end
    if (lim_wr) m_user = int'(lim_data);
    x.busy  = m_busy;
    x.count = 8'(m_count);
    exp_q.push_back(x);
  endtask

  task automatic step(input bit e_i, s_i, p_i, input logic [1:0] sl, md, input logic [3:0] bl);
    en = e_i; start = s_i; stop = p_i; sel = sl; mode = md; blen = bl;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (tick) tick_seen++;
    if (done) done_seen++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("cycle{tick,done,busy,count}", int'({tick, done, busy, cnt}), int'(e));
    end
  end

  int t0, d0;

  initial begin
    model_reset();
    #2;
    chk("reset_outputs", int'({tick, done, busy, cnt}), 0);
    #10;
    rst = 1'b0;

    // Continuous, period 4
    settle(); t0 = tick_seen; d0 = done_seen;
    step(1, 1, 0, 2'd0, 2'd0, 4'd0);
    repeat (16) step(1, 0, 0, 2'd0, 2'd0, 4'd0);
    settle();
    chk("cont_ticks", tick_seen - t0, 4);
    chk("cont_done", done_seen - d0, 0);
    step(1, 0, 1, 2'd0, 2'd0, 4'd0);

    // Burst of 3 at period 8, then burst length 0
    settle(); t0 = tick_seen; d0 = done_seen;
    step(1, 1, 0, 2'd1, 2'd2, 4'd3);
    repeat (24) step(1, 0, 0, 2'd1, 2'd0, 4'd0);
    settle();
    chk("burst3_ticks", tick_seen - t0, 3);
    chk("burst3_done", done_seen - d0, 1);
    chk("burst3_busy_after", int'(busy), 0);
    t0 = tick_seen;
    step(1, 1, 0, 2'd1, 2'd2, 4'd0);
    repeat (12) step(1, 0, 0, 2'd1, 2'd2, 4'd0);
    settle();
    chk("burst0_ticks", tick_seen - t0, 1);

    // One-shot with enable gap at count 2
    settle(); t0 = tick_seen;
    step(1, 1, 0, 2'd0, 2'd1, 4'd0);
    repeat (2) step(1, 0, 0, 2'd0, 2'd1, 4'd0);
    repeat (5) step(0, 0, 0, 2'd0, 2'd1, 4'd0);
    settle();
    chk("gate_hold_count", int'(cnt), 2);
    repeat (2) step(1, 0, 0, 2'd0, 2'd1, 4'd0);
    settle();
    chk("gate_late_tick", tick_seen - t0, 1);

    // Stop coinciding with terminal count, then start+stop from idle
    settle(); t0 = tick_seen; d0 = done_seen;
    step(1, 1, 0, 2'd0, 2'd0, 4'd0);
    repeat (3) step(1, 0, 0, 2'd0, 2'd0, 4'd0);
    step(1, 0, 1, 2'd0, 2'd0, 4'd0);
    settle();
    chk("stop_no_tick", tick_seen - t0, 0);
    chk("stop_no_done", done_seen - d0, 0);
    step(1, 1, 1, 2'd0, 2'd0, 4'd0);
    settle();
    chk("start_stop_idle", int'(busy), 0);

    // Limit reduced mid-period
    settle(); t0 = tick_seen;
    step(1, 1, 0, 2'd3, 2'd0, 4'd0);
    repeat (20) step(1, 0, 0, 2'd3, 2'd0, 4'd0);
    step(1, 0, 0, 2'd0, 2'd0, 4'd0);
    repeat (4) step(1, 0, 0, 2'd0, 2'd0, 4'd0);
    settle();
    chk("limit_change_ticks", tick_seen - t0, 2);
    step(1, 0, 1, 2'd0, 2'd0, 4'd0);

    // Randomised traffic
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(7) != 0), ($urandom_range(3) == 0), ($urandom_range(39) == 0),
           2'($urandom_range(3)), 2'($urandom_range(3)), 4'($urandom_range(15)));
    end
    step(1, 0, 1, 2'd0, 2'd0, 4'd0);

    // Asynchronous reset with a tick in flight
    step(1, 1, 0, 2'd0, 2'd2, 4'd5);
    repeat (4) step(1, 0, 0, 2'd0, 2'd2, 4'd0);
    settle();
    rst = 1'b1;
    #1;
    chk("async_reset_outputs", int'({tick, done, busy, cnt}), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

`ifdef TICK_PRESCALER_USER_LIMIT_EN
    lim_wr = 1'b1; lim_data = 8'd0;
    step(0, 0, 0, 2'd0, 2'd0, 4'd0);
    lim_wr = 1'b0;
    settle(); t0 = tick_seen;
    step(1, 1, 0, 2'd3, 2'd0, 4'd0);
    repeat (6) step(1, 0, 0, 2'd3, 2'd0, 4'd0);
    settle();
    chk("user_limit0_ticks", tick_seen - t0, 6);
    step(1, 0, 1, 2'd3, 2'd0, 4'd0);
`endif

    settle();
    settle();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/tick_prescaler.md
# tick_prescaler

Parametrised prescaler that turns the board clock into a programmable-rate one-cycle enable pulse for downstream shift registers and LED sequencers. It supports selectable power-of-two periods, explicit start/stop, and three run modes: continuous, one-shot, and a burst of N ticks with a completion pulse. It sits between the switch/button front end and any block consuming `o_shift_enable`.

## Interface
- `NB_COUNT`, 32: counter width.
- `NB_SEL`, 2: width of the period selector; there are 2^NB_SEL preset limits.
- `SHIFT_BASE`, 10: preset limit k is R_k = 2^(NB_COUNT-SHIFT_BASE+k)-1. SHIFT_BASE must be >= 2^NB_SEL-1.
- `NB_BURST`, 8: width of the burst length.

- `clk` in 1: single clock; all state updates on its rising edge.
- `i_ck_reset` in 1: asynchronous, active-high reset.
- `i_count_enable` in 1: gates counting; while low the counter and state freeze.
- `i_count_sel` in NB_SEL: selects preset limit R_k, where k = i_count_sel. Sampled every cycle.
- `i_mode` in 2: 00 continuous, 01 one-shot, 10 burst, 11 behaves as continuous. Latched at start.
- `i_start` in 1: level-sampled start request.
- `i_stop` in 1: abort request.
- `i_burst_len` in NB_BURST: tick count for burst mode, latched at start. A value of 0 is treated as 1.
- `o_shift_enable` out 1: registered one-cycle tick.
- `o_done` out 1: registered one-cycle pulse when a one-shot or burst completes.
- `o_busy` out 1: high while in RUN.
- `o_count` out NB_COUNT: current counter value.

## Operation
- FSM states are IDLE and RUN. On reset: state IDLE, counter 0, remaining 0, and all outputs 0.
- **IDLE**
  - Counter is held at 0.
  - If `i_start`=1, `i_stop`=0 and `i_count_enable`=1, the block enters RUN with counter 0.
  - On that entry it latches mode and sets remaining = 1 (one-shot), `i_burst_len` (burst, 0→1), or don't-care (continuous).
- **RUN with `i_count_enable`=1**
  - If counter >= limit: counter←0 and `o_shift_enable`←1 for one cycle.
  - On that terminal event in one-shot or burst mode, remaining is decremented.
  - If remaining was 1: `o_done`←1 for one cycle and the FSM returns to IDLE.
  - Otherwise the counter increments by 1.
- **RUN with `i_count_enable`=0**
  - Counter, remaining and state hold; no tick is produced.
- **`i_stop`=1 in RUN**
  - Next state is IDLE and the counter goes to 0.
  - No tick and no done, even if the terminal condition coincides.
  - Stop beats start when both are asserted in the same cycle.
- **`i_start` while in RUN**: ignored.
- **Limit changes mid-period**: the comparison is >=, so reducing the limit below the current count terminates the period on the next enabled edge. Raising the limit extends the current period.
- **Width rule**: the counter never exceeds the selected limit, so no wrap past 2^NB_COUNT-1 occurs.

## Timing
- Start sampled at edge E0 → `o_busy`=1 after E0 and counter=0.
- First tick is high during the cycle after edge E(R+1).
- Tick period is R+1 enabled cycles, and the tick is exactly one cycle wide.
- `o_done` is asserted in the same cycle as the final `o_shift_enable`. `o_busy` falls on that same edge.
- A new start is accepted on the edge after `o_busy` falls (the first IDLE cycle).
- Reset asserted mid-run clears all outputs immediately (asynchronous), including a tick in flight.

## Configuration
- Macro: `TICK_PRESCALER_USER_LIMIT_EN`.
- **Defined**
  - Adds inputs `i_limit_wr` (1 bit) and `i_limit_data` (NB_COUNT bits), plus a user-limit register with reset value R0.
  - `i_limit_wr`=1 loads the register on the next edge.
  - When `i_count_sel` is all ones, the user limit replaces the top preset.
  - A user limit of 0 produces a tick on every enabled cycle in RUN.
- **Undefined**: these ports and the register are absent, and all-ones selects R_(2^NB_SEL-1).

## Test plan
Configuration for all scenarios: NB_COUNT=8, SHIFT_BASE=6, NB_BURST=4, so R0=3, R1=7, R2=15, R3=31.

- **Continuous**: mode 00, sel 0, start for 1 cycle, enable high → ticks at cycles 4, 8, 12, … after start, each 1 cycle wide; `o_done` never asserts.
- **Burst**: mode 10, burst_len 3, sel 1 → exactly 3 ticks spaced 8 cycles apart; `o_done` coincides with the 3rd tick; `o_busy` low afterwards. A second burst with burst_len 0 yields 1 tick.
- **Enable gating**: one-shot, sel 0, enable dropped for 5 cycles at count 2 → `o_count` holds 2; the tick arrives 5 cycles late.
- **Stop at terminal**: continuous, sel 0, stop asserted in the cycle with count 3 → no tick, no done, IDLE, count 0. Start+stop in the same cycle from IDLE → stays IDLE.
- **Limit change**: sel 3 running at count 20, switch sel to 0 → tick on the next enabled edge, then a period of 4.
- **Reset**: reset asserted mid-burst → all outputs 0 asynchronously. With `TICK_PRESCALER_USER_LIMIT_EN`, write limit 0 and select sel 3 → `o_shift_enable` high on every RUN cycle.
